stream_stats_monitor: RTL and testbench

Parametrised, multi-channel successor to the single-purpose per-port stats counters used around the pattern-matching services. It passively taps NUM_CH valid/ready/sop/eop streams plus per-channel FIFO occupancy. Per channel it keeps flit, packet, framing-error and maximum-occupancy statistics, with atomic snapshot and read-and-clear. Results are returned through a one-cycle-latency indexed read port for the CSR/stats path.

---
 rtl/stream_stats_monitor.sv | 164 ++++++++++++++++
 tb/tb_stream_stats_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_stats_monitor.sv
// stream_stats_monitor
// Passive per-channel stream statistics: flit, packet, framing-error and
// maximum-occupancy counters, with a shadow snapshot set, read-and-clear,
// and a one-cycle-latency indexed read port.
// Optional feature macro: STATS_SATURATE_EN (counters saturate instead of wrap).
module stream_stats_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int OCC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH-1:0]       ch_ready,
  input  logic [NUM_CH-1:0]       ch_sop,
  input  logic [NUM_CH-1:0]       ch_eop,
  input  logic [NUM_CH*OCC_W-1:0] ch_occ,
  input  logic                    clear,
  input  logic                    snap,
  input  logic                    rd_req,
  input  logic [3:0]              rd_sel,
  input  logic [1:0]              rd_kind,
  output logic                    rd_valid,
  output logic [CNT_W-1:0]        rd_data
);

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} fsm_t;

  fsm_t state     [NUM_CH];
  fsm_t state_nxt [NUM_CH];

  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] pkt_inc;
  logic [NUM_CH-1:0] err_inc;

  logic [CNT_W-1:0] occ_ext  [NUM_CH];
  logic [CNT_W-1:0] live_flit[NUM_CH];
  logic [CNT_W-1:0] live_pkt [NUM_CH];
  logic [CNT_W-1:0] live_err [NUM_CH];
  logic [CNT_W-1:0] live_max [NUM_CH];
  logic [CNT_W-1:0] nxt_flit [NUM_CH];
  logic [CNT_W-1:0] nxt_pkt  [NUM_CH];
  logic [CNT_W-1:0] nxt_err  [NUM_CH];
  logic [CNT_W-1:0] nxt_max  [NUM_CH];
  logic [CNT_W-1:0] shd_flit [NUM_CH];
  logic [CNT_W-1:0] shd_pkt  [NUM_CH];
  logic [CNT_W-1:0] shd_err  [NUM_CH];
  logic [CNT_W-1:0] shd_max  [NUM_CH];

  logic [CNT_W-1:0] rd_mux;

  // Next event counter value: clear restarts from this cycle's increment,
  // so an event coinciding with clear is never lost.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                            input logic inc,
                                            input logic clr);
    logic [CNT_W-1:0] r;
    r = v;
    if (clr) begin
      r = CNT_W'(inc);
    end else if (inc) begin
`ifdef STATS_SATURATE_EN
      if (!(&v)) r = v + CNT_W'(1);
`else
      r = v + CNT_W'(1);
`endif
    end
    return r;
  endfunction

  // Framing FSM next state and per-channel event strobes.
  always_comb begin
    acc     = '0;
    pkt_inc = '0;
    err_inc = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_nxt[c] = state[c];
      acc[c]       = ch_valid[c] & ch_ready[c];
      pkt_inc[c]   = acc[c] & ch_eop[c];
      // A missing sop in IDLE or an unexpected sop in IN_PKT is a framing
      // error; either way the flit is taken as the start of a packet, so the
      // next state depends only on eop.
      err_inc[c]   = acc[c] & ((state[c] == IDLE) ? ~ch_sop[c] : ch_sop[c]);
      if (acc[c]) state_nxt[c] = ch_eop[c] ? IDLE : IN_PKT;
    end
  end

  // Framing FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) state[c] <= IDLE;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) state[c] <= state_nxt[c];
    end
  end

  // Next live statistics, including clear handling.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      occ_ext[c]  = CNT_W'(ch_occ[c*OCC_W +: OCC_W]);
      nxt_flit[c] = bump(live_flit[c], acc[c], clear);
      nxt_pkt[c]  = bump(live_pkt[c], pkt_inc[c], clear);
      nxt_err[c]  = bump(live_err[c], err_inc[c], clear);
      if (clear || (occ_ext[c] > live_max[c])) nxt_max[c] = occ_ext[c];
      else                                     nxt_max[c] = live_max[c];
    end
  end

  // Live and shadow statistic registers; shadow captures pre-update live values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        live_flit[c] <= '0;
        live_pkt[c]  <= '0;
        live_err[c]  <= '0;
        live_max[c]  <= '0;
        shd_flit[c]  <= '0;
        shd_pkt[c]   <= '0;
        shd_err[c]   <= '0;
        shd_max[c]   <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        live_flit[c] <= nxt_flit[c];
        live_pkt[c]  <= nxt_pkt[c];
        live_err[c]  <= nxt_err[c];
        live_max[c]  <= nxt_max[c];
        if (snap) begin
          shd_flit[c] <= live_flit[c];
          shd_pkt[c]  <= live_pkt[c];
          shd_err[c]  <= live_err[c];
          shd_max[c]  <= live_max[c];
        end
      end
    end
  end

  // Shadow read mux; out-of-range channel selects read as zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rd_sel == 4'(c)) begin
        case (rd_kind)
          2'd0:    rd_mux = shd_pkt[c];
          2'd1:    rd_mux = shd_flit[c];
          2'd2:    rd_mux = shd_max[c];
          default: rd_mux = shd_err[c];
        endcase
      end
    end
  end

  // Registered read response, one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= rd_req ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_stream_stats_monitor.sv
// Self-checking bench for stream_stats_monitor (NUM_CH=4, CNT_W=8, OCC_W=8).
// Expected read values are queued as requests are driven and compared when
// rd_valid is observed.
module tb_stream_stats_monitor;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int OCC_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       ch_valid, ch_ready, ch_sop, ch_eop;
  logic [NUM_CH*OCC_W-1:0] ch_occ;
  logic                    clear, snap, rd_req;
  logic [3:0]              rd_sel;
  logic [1:0]              rd_kind;
  logic                    rd_valid;
  logic [CNT_W-1:0]        rd_data;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_q[$];
  string            tag_q[$];
  logic             req_s = 1'b0;

`ifdef STATS_SATURATE_EN
  localparam logic [CNT_W-1:0] OVF_EXP = 8'd255;
`else
  localparam logic [CNT_W-1:0] OVF_EXP = 8'd4;
`endif

  stream_stats_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .OCC_W(OCC_W)) dut (
    .clk(clk), .rst(rst),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_sop(ch_sop), .ch_eop(ch_eop),
    .ch_occ(ch_occ), .clear(clear), .snap(snap),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_kind(rd_kind),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Request sampled by the DUT at each edge (reset wins over rd_req).
  always @(posedge clk) req_s <= rd_req & ~rst;

  // Response monitor: timing of rd_valid and scoreboard comparison of rd_data.
  always @(negedge clk) begin
    chk("rd_valid_timing", CNT_W'(rd_valid), CNT_W'(req_s));
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd", CNT_W'(exp_q.size()), 8'd1);
      end else begin
        chk(tag_q.pop_front(), rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flit(input int ch, input logic s, input logic e, input logic r);
    ch_valid = '0; ch_ready = '0; ch_sop = '0; ch_eop = '0;
    ch_valid[ch] = 1'b1;
    ch_ready[ch] = r;
    ch_sop[ch]   = s;
    ch_eop[ch]   = e;
    step();
    ch_valid = '0; ch_ready = '0; ch_sop = '0; ch_eop = '0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    step();
    snap = 1'b0;
  endtask

  task automatic rd(input logic [3:0] sel, input logic [1:0] kind,
                    input logic [CNT_W-1:0] e, input string tag);
    rd_req  = 1'b1;
    rd_sel  = sel;
    rd_kind = kind;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    step();
    rd_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    chk("drain_pending", CNT_W'(exp_q.size()), 8'd0);
    exp_q.delete();
    tag_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    ch_valid = '0; ch_ready = '0; ch_sop = '0; ch_eop = '0; ch_occ = '0;
    clear = 1'b0; snap = 1'b0; rd_req = 1'b0; rd_sel = '0; rd_kind = '0;
    step(); step(); step();
    chk("reset_rd_valid", CNT_W'(rd_valid), 8'd0);
    chk("reset_rd_data", rd_data, 8'd0);
    rst = 1'b0;
    step();

    // Reset values of the shadow set
    rd(0, 0, 0, "reset_pkts");
    rd(0, 1, 0, "reset_flits");
    rd(0, 2, 0, "reset_max");
    rd(0, 3, 0, "reset_errs");
    step();

    // Channel 0: packets of 1, 4 and 2 flits
    flit(0, 1, 1, 1);
    flit(0, 1, 0, 1); flit(0, 0, 0, 1); flit(0, 0, 0, 1); flit(0, 0, 1, 1);
    flit(0, 1, 0, 1); flit(0, 0, 1, 1);
    do_snap();
    rd(0, 0, 3, "ch0_pkts");
    rd(0, 1, 7, "ch0_flits");
    rd(0, 3, 0, "ch0_errs");
    step();

    // Channel 2: 6-flit packet with ready toggling; ready=0 cycles count nothing
    for (int k = 0; k < 6; k++) begin
      flit(2, (k == 0), (k == 5), 1'b0);
      flit(2, (k == 0), (k == 5), 1'b1);
    end
    do_snap();
    rd(2, 1, 6, "ch2_flits");
    rd(2, 0, 1, "ch2_pkts");
    rd(2, 3, 0, "ch2_errs");
    step();

    // Channel 1: stray body from IDLE, sop inside packet, then a clean packet
    flit(1, 0, 0, 1);
    flit(1, 0, 0, 1);
    flit(1, 1, 0, 1);
    flit(1, 0, 1, 1);
    flit(1, 1, 0, 1);
    flit(1, 0, 1, 1);
    do_snap();
    rd(1, 3, 2, "ch1_errs");
    rd(1, 0, 2, "ch1_pkts");
    rd(1, 1, 6, "ch1_flits");
    step();

    // Channel 3 occupancy maximum, then clear reloads current occupancy
    ch_occ[3*OCC_W +: OCC_W] = 8'd5;  step();
    ch_occ[3*OCC_W +: OCC_W] = 8'd17; step();
    ch_occ[3*OCC_W +: OCC_W] = 8'd9;  step();
    ch_occ = '0;
    do_snap();
    rd(3, 2, 17, "ch3_max");
    clear = 1'b1;
    ch_occ[3*OCC_W +: OCC_W] = 8'd4;
    step();
    clear = 1'b0;
    ch_occ = '0;
    do_snap();
    rd(3, 2, 4, "ch3_max_after_clear");
    rd(0, 0, 0, "ch0_pkts_after_clear");
    step();

    // Atomic read-and-clear coinciding with an accepted eop
    for (int k = 0; k < 10; k++) flit(0, 1, 1, 1);
    snap = 1'b1; clear = 1'b1;
    flit(0, 1, 1, 1);
    snap = 1'b0; clear = 1'b0;
    rd(0, 0, 10, "snapclr_shadow");
    snap = 1'b1;
    rd(0, 0, 10, "read_during_snap");
    snap = 1'b0;
    rd(0, 0, 1, "after_second_snap");
    step();

    // Counter overflow with CNT_W=8 and out-of-range channel select
    clear = 1'b1; step(); clear = 1'b0;
    for (int k = 0; k < 260; k++) flit(0, 1, 1, 1);
    do_snap();
    rd(0, 0, OVF_EXP, "ovf_pkts");
    rd(0, 1, OVF_EXP, "ovf_flits");
    rd(0, 3, 0, "ovf_errs");
    rd(7, 0, 0, "sel7_pkts");
    rd(4, 1, 0, "sel4_flits");
    step();
    drain();

    // Reset mid-packet returns the FSM to IDLE
    flit(1, 1, 0, 1);
    rst = 1'b1; step(); step(); rst = 1'b0;
    flit(1, 0, 1, 1);
    do_snap();
    rd(1, 3, 1, "rst_midpkt_errs");
    rd(1, 0, 1, "rst_midpkt_pkts");
    rd(0, 0, 0, "rst_ch0_pkts");
    step();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
